// File: rtl/aes_ctr_pkg.sv
// rtl/aes_ctr_pkg.sv - shared types and widths for the AES-CTR sequencer
package aes_ctr_pkg;

  localparam int BLK_W       = 128;
  localparam int NONCE_W_DEF = 96;
  localparam int CTR_W_DEF   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_e;

endpackage

// File: rtl/aes_ctr_sequencer_if.sv
// rtl/aes_ctr_sequencer_if.sv - AES core handshake plus plaintext/ciphertext streams
interface aes_ctr_sequencer_if;
  import aes_ctr_pkg::*;

  logic [BLK_W-1:0] aes_block;
  logic             aes_start;
  logic             aes_done;
  logic [BLK_W-1:0] aes_result;

  logic [BLK_W-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             din_last;

  logic [BLK_W-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;

  modport master (
    output aes_block, aes_start, din_ready, dout, dout_valid,
    input  aes_done, aes_result, din, din_valid, din_last, dout_ready
  );

  modport slave (
    input  aes_block, aes_start, din_ready, dout, dout_valid,
    output aes_done, aes_result, din, din_valid, din_last, dout_ready
  );

endinterface

// File: rtl/aes_ctr_sequencer.sv
// rtl/aes_ctr_sequencer.sv - CTR-mode keystream sequencer around an external AES core
// AES_CTR_WRAP_GUARD_EN: stop at counter overflow instead of wrapping silently.
module aes_ctr_sequencer
  import aes_ctr_pkg::*;
#(
  parameter int NONCE_W = NONCE_W_DEF,
  parameter int CTR_W   = CTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NONCE_W-1:0] nonce,
  input  logic [CTR_W-1:0]   ctr_init,
  output logic               busy,
  output logic               ctr_wrap,
  aes_ctr_sequencer_if.master bus
);

  state_e             state_q, state_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [CTR_W-1:0]   ctr_q, ctr_d;
  logic [BLK_W-1:0]   ks_q, ks_d;
  logic               ks_valid_q, ks_valid_d;
  logic [BLK_W-1:0]   dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;
  logic               ctr_wrap_q, ctr_wrap_d;
  logic               din_ready;
  logic               din_hs;

  // A new block may enter only when the output register is free or draining this cycle.
  assign din_ready = (state_q == HOLD) && ks_valid_q && (!dout_valid_q || bus.dout_ready);
  assign din_hs    = din_ready && bus.din_valid;

  always_comb begin
    state_d      = state_q;
    nonce_d      = nonce_q;
    ctr_d        = ctr_q;
    ks_d         = ks_q;
    ks_valid_d   = ks_valid_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    ctr_wrap_d   = ctr_wrap_q;

    if (dout_valid_q && bus.dout_ready) begin
      dout_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          nonce_d    = nonce;
          ctr_d      = ctr_init;
          ctr_wrap_d = 1'b0;
          state_d    = REQ;
        end
      end
      REQ: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.aes_done) begin
          ks_d       = bus.aes_result;
          ks_valid_d = 1'b1;
          ctr_d      = ctr_q + CTR_W'(1);
          state_d    = HOLD;
          if (&ctr_q) begin
            ctr_wrap_d = 1'b1;
`ifdef AES_CTR_WRAP_GUARD_EN
            ks_d       = '0;
            ks_valid_d = 1'b0;
            state_d    = IDLE;
`endif
          end
        end
      end
      HOLD: begin
        if (din_hs) begin
          dout_d       = bus.din ^ ks_q;
          dout_valid_d = 1'b1;
          ks_valid_d   = 1'b0;
          state_d      = bus.din_last ? IDLE : REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      nonce_q      <= '0;
      ctr_q        <= '0;
      ks_q         <= '0;
      ks_valid_q   <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      ctr_wrap_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      nonce_q      <= nonce_d;
      ctr_q        <= ctr_d;
      ks_q         <= ks_d;
      ks_valid_q   <= ks_valid_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      ctr_wrap_q   <= ctr_wrap_d;
    end
  end

  assign bus.aes_block  = {nonce_q, ctr_q};
  assign bus.aes_start  = (state_q == REQ);
  assign bus.din_ready  = din_ready;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign busy           = (state_q != IDLE);
  assign ctr_wrap       = ctr_wrap_q;

endmodule

// File: tb/tb_aes_ctr_sequencer.sv
// tb/tb_aes_ctr_sequencer.sv - directed self-checking bench for aes_ctr_sequencer
module tb_aes_ctr_sequencer;
  import aes_ctr_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [95:0] nonce;
  logic [31:0] ctr_init;
  logic        busy;
  logic        ctr_wrap;

  int checks = 0;
  int passed = 0;

  logic [127:0] ones = {128{1'b1}};
  logic [95:0]  n1 = 96'hA5A5A5A5_A5A5A5A5_A5A5A5A5;
  logic [95:0]  n2 = 96'h01234567_89ABCDEF_00112233;
  logic [95:0]  n3 = 96'hDEADBEEF_CAFEF00D_13579BDF;
  logic [127:0] d_exp;
  logic [127:0] d_hold;

  aes_ctr_sequencer_if bus ();

  aes_ctr_sequencer #(.NONCE_W(96), .CTR_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .nonce    (nonce),
    .ctr_init (ctr_init),
    .busy     (busy),
    .ctr_wrap (ctr_wrap),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_aes_start(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.aes_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_aes_start_seen"}, 128'(seen), 128'(1));
  endtask

  // Model core: result = block ^ all-ones, ten cycles after the request.
  task automatic core_serve(input string tag, input logic [95:0] n, input logic [31:0] c);
    logic [127:0] blk;
    wait_aes_start(tag);
    check({tag, "_aes_block"}, bus.aes_block, {n, c});
    blk = bus.aes_block;
    repeat (10) tick();
    check({tag, "_aes_block_stable"}, bus.aes_block, {n, c});
    bus.aes_done   = 1'b1;
    bus.aes_result = blk ^ ones;
    tick();
    bus.aes_done   = 1'b0;
  endtask

  task automatic send_block(input string tag, input logic [127:0] d, input logic last);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.din_ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_din_ready_seen"}, 128'(seen), 128'(1));
    bus.din       = d;
    bus.din_valid = 1'b1;
    bus.din_last  = last;
    tick();
    bus.din_valid = 1'b0;
    bus.din_last  = 1'b0;
  endtask

  task automatic pulse_start(input logic [95:0] n, input logic [31:0] c);
    nonce    = n;
    ctr_init = c;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    start          = 1'b0;
    nonce          = '0;
    ctr_init       = '0;
    bus.aes_done   = 1'b0;
    bus.aes_result = '0;
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.din_last   = 1'b0;
    bus.dout_ready = 1'b1;
    repeat (3) tick();

    check("rst_busy", 128'(busy), 128'(0));
    check("rst_aes_start", 128'(bus.aes_start), 128'(0));
    check("rst_dout_valid", 128'(bus.dout_valid), 128'(0));
    check("rst_din_ready", 128'(bus.din_ready), 128'(0));
    check("rst_ctr_wrap", 128'(ctr_wrap), 128'(0));
    check("rst_aes_block", bus.aes_block, 128'(0));
    check("rst_dout", bus.dout, 128'(0));
    rst = 1'b0;
    tick();

    // Three blocks, counters 1..3, last on the third.
    pulse_start(n1, 32'd1);
    check("t1_busy", 128'(busy), 128'(1));
    for (int k = 1; k <= 3; k++) begin
      d_exp = {4{32'h1000_0000 + 32'(k)}};
      core_serve("t1", n1, 32'(k));
      send_block("t1", d_exp, (k == 3));
      check("t1_dout", bus.dout, d_exp ^ {n1, 32'(k)} ^ ones);
      check("t1_dout_valid", 128'(bus.dout_valid), 128'(1));
    end
    check("t1_idle", 128'(busy), 128'(0));
    tick();
    check("t1_drained", 128'(bus.dout_valid), 128'(0));

    // Back-pressure: first dout held while the prefetched keystream waits.
    bus.dout_ready = 1'b0;
    pulse_start(n2, 32'd5);
    core_serve("t2a", n2, 32'd5);
    send_block("t2a", 128'h0F0F_0F0F_1111_2222_3333_4444_5555_6666, 1'b0);
    d_hold = 128'h0F0F_0F0F_1111_2222_3333_4444_5555_6666 ^ {n2, 32'd5} ^ ones;
    check("t2_dout0", bus.dout, d_hold);
    core_serve("t2b", n2, 32'd6);
    bus.din       = 128'h7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE;
    bus.din_valid = 1'b1;
    bus.din_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t2_stall_din_ready", 128'(bus.din_ready), 128'(0));
      check("t2_stall_dout", bus.dout, d_hold);
      check("t2_stall_dout_valid", 128'(bus.dout_valid), 128'(1));
      tick();
    end
    bus.dout_ready = 1'b1;
    #1;
    check("t2_release_din_ready", 128'(bus.din_ready), 128'(1));
    tick();
    bus.din_valid = 1'b0;
    bus.din_last  = 1'b0;
    check("t2_dout1", bus.dout, 128'h7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE ^ {n2, 32'd6} ^ ones);
    check("t2_idle", 128'(busy), 128'(0));
    tick();
    check("t2_drained", 128'(bus.dout_valid), 128'(0));

    // Counter overflow.
    pulse_start(n3, 32'hFFFF_FFFF);
    core_serve("t3a", n3, 32'hFFFF_FFFF);
    check("t3_ctr_wrap", 128'(ctr_wrap), 128'(1));
`ifdef AES_CTR_WRAP_GUARD_EN
    check("t3_guard_idle", 128'(busy), 128'(0));
    check("t3_guard_din_ready", 128'(bus.din_ready), 128'(0));
    bus.din_valid = 1'b1;
    repeat (3) tick();
    bus.din_valid = 1'b0;
    check("t3_guard_no_dout", 128'(bus.dout_valid), 128'(0));
`else
    send_block("t3a", 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 1'b0);
    check("t3_dout0", bus.dout, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321 ^ {n3, 32'hFFFF_FFFF} ^ ones);
    core_serve("t3b", n3, 32'd0);
    send_block("t3b", 128'hAAAA_5555_AAAA_5555_AAAA_5555_AAAA_5555, 1'b1);
    check("t3_dout1", bus.dout, 128'hAAAA_5555_AAAA_5555_AAAA_5555_AAAA_5555 ^ {n3, 32'd0} ^ ones);
    check("t3_wrap_sticky", 128'(ctr_wrap), 128'(1));
    check("t3_idle", 128'(busy), 128'(0));
`endif
    tick();

    // Start during WAIT is ignored; new start clears ctr_wrap.
    pulse_start(n2, 32'd7);
    check("t4_wrap_cleared", 128'(ctr_wrap), 128'(0));
    wait_aes_start("t4");
    tick();
    pulse_start(n3, 32'd99);
    tick();
    check("t4_aes_block", bus.aes_block, {n2, 32'd7});
    check("t4_busy", 128'(busy), 128'(1));
    check("t4_no_new_req", 128'(bus.aes_start), 128'(0));

    // Reset while in WAIT, then a stale aes_done.
    rst = 1'b1;
    #1;
    check("t5_busy", 128'(busy), 128'(0));
    check("t5_aes_start", 128'(bus.aes_start), 128'(0));
    check("t5_aes_block", bus.aes_block, 128'(0));
    check("t5_dout", bus.dout, 128'(0));
    check("t5_dout_valid", 128'(bus.dout_valid), 128'(0));
    check("t5_din_ready", 128'(bus.din_ready), 128'(0));
    tick();
    rst            = 1'b0;
    bus.aes_done   = 1'b1;
    bus.aes_result = 128'hFEED_FACE_0000_1111_2222_3333_4444_5555;
    tick();
    bus.aes_done   = 1'b0;
    check("t5_stale_busy", 128'(busy), 128'(0));
    check("t5_stale_dout_valid", 128'(bus.dout_valid), 128'(0));
    check("t5_stale_din_ready", 128'(bus.din_ready), 128'(0));

    // aes_done in IDLE.
    bus.aes_done = 1'b1;
    tick();
    bus.aes_done = 1'b0;
    tick();
    check("t6_busy", 128'(busy), 128'(0));
    check("t6_aes_block", bus.aes_block, 128'(0));
    check("t6_din_ready", 128'(bus.din_ready), 128'(0));
    check("t6_dout_valid", 128'(bus.dout_valid), 128'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
